// File: rtl/abc_sweep_gen_pkg.sv
// Shared definitions for the A/B/C operand sweep generator.
//   - state_t   : sequencer states (IDLE, three sweep phases, DONE)
//   - PH_CODE_* : values driven on the 2-bit phase output
//   - W_DEF     : default operand width, MAX_DEF its all-ones value
//   - phase_of(): maps a state to its phase code
package abc_sweep_gen_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PH_A = 3'd1,
    ST_PH_B = 3'd2,
    ST_PH_C = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  localparam logic [1:0] PH_CODE_A    = 2'b00;
  localparam logic [1:0] PH_CODE_B    = 2'b01;
  localparam logic [1:0] PH_CODE_C    = 2'b10;
  localparam logic [1:0] PH_CODE_REST = 2'b11;

  localparam int W_DEF   = 4;
  localparam int MAX_DEF = (1 << W_DEF) - 1;

  function automatic logic [1:0] phase_of(input state_t st);
    case (st)
      ST_PH_A: phase_of = PH_CODE_A;
      ST_PH_B: phase_of = PH_CODE_B;
      ST_PH_C: phase_of = PH_CODE_C;
      default: phase_of = PH_CODE_REST;
    endcase
  endfunction

endpackage

// File: rtl/abc_sweep_gen_digit.sv
// sweep_digit: one W-bit digit of the operand sweep.
// Ports:
//   clk, reset  : clock, asynchronous active-high reset (value -> 0)
//   inc         : add one (wraps MAX -> 0, no saturation)
//   clr         : force to 0 (highest priority)
//   load_one    : force to 1 (beats inc)
//   value       : registered digit value
//   value_next  : value the digit takes on the next edge (for look-ahead flags)
//   wrap        : value == MAX
module sweep_digit
  import abc_sweep_gen_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         clr,
  input  logic         load_one,
  output logic [W-1:0] value,
  output logic [W-1:0] value_next,
  output logic         wrap
);

  always_comb begin
    value_next = value;
    if (clr)
      value_next = '0;
    else if (load_one)
      value_next = W'(1);
    else if (inc)
      value_next = value + W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      value <= '0;
    else
      value <= value_next;
  end

  assign wrap = (value == {W{1'b1}});

endmodule

// File: rtl/abc_sweep_gen.sv
// abc_sweep_gen: emits every (A_e, B_e, C_e) triple exactly once over a
// valid/ready handshake in three phases: A only, then A+B (B>=1), then
// A+B+C (C>=1). All outputs are registered.
// Ports:
//   clk, reset       : clock, asynchronous active-high reset
//   start            : begin a sweep (honoured in IDLE/DONE only)
//   abort            : return to IDLE (honoured in the sweep phases only)
//   out_ready        : consumer accepts the current vector
//   out_valid        : A_e/B_e/C_e carry a vector
//   A_e, B_e, C_e    : operands
//   out_last         : current vector is the final one of the sweep
//   phase            : 00=A, 01=B, 10=C, 11=IDLE/DONE
//   busy, done       : in a sweep phase / in DONE
//   vec_cnt          : completed transfers since last start (saturating)
module abc_sweep_gen
  import abc_sweep_gen_pkg::*;
#(
  parameter int W     = W_DEF,
  parameter int CNT_W = 3 * W + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [W-1:0]     A_e,
  output logic [W-1:0]     B_e,
  output logic [W-1:0]     C_e,
  output logic             out_last,
  output logic [1:0]       phase,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] vec_cnt
);

  localparam logic [W-1:0]     MAX     = {W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(1) << (3 * W);

  state_t state_reg, state_next;

  logic a_inc, a_clr, a_one;
  logic b_inc, b_clr, b_one;
  logic c_inc, c_clr, c_one;
  logic a_wrap, b_wrap, c_wrap;
  logic [W-1:0] a_nxt, b_nxt, c_nxt;
  logic cnt_inc, cnt_clr;
  logic xfer;
  logic in_sweep_next;
  logic out_last_next;

  sweep_digit #(.W(W)) u_digit_a (
    .clk(clk), .reset(reset), .inc(a_inc), .clr(a_clr), .load_one(a_one),
    .value(A_e), .value_next(a_nxt), .wrap(a_wrap)
  );

  sweep_digit #(.W(W)) u_digit_b (
    .clk(clk), .reset(reset), .inc(b_inc), .clr(b_clr), .load_one(b_one),
    .value(B_e), .value_next(b_nxt), .wrap(b_wrap)
  );

  sweep_digit #(.W(W)) u_digit_c (
    .clk(clk), .reset(reset), .inc(c_inc), .clr(c_clr), .load_one(c_one),
    .value(C_e), .value_next(c_nxt), .wrap(c_wrap)
  );

  assign xfer = out_valid && out_ready;

  always_comb begin
    state_next = state_reg;
    a_inc = 1'b0; a_clr = 1'b0; a_one = 1'b0;
    b_inc = 1'b0; b_clr = 1'b0; b_one = 1'b0;
    c_inc = 1'b0; c_clr = 1'b0; c_one = 1'b0;
    cnt_inc = 1'b0;
    cnt_clr = 1'b0;

    case (state_reg)
      ST_IDLE, ST_DONE: begin
        // start beats abort here; abort has no meaning outside a sweep
        if (start) begin
          state_next = ST_PH_A;
          a_clr = 1'b1; b_clr = 1'b1; c_clr = 1'b1;
          cnt_clr = 1'b1;
        end
      end

      ST_PH_A: begin
        if (abort) begin
          state_next = ST_IDLE;
          a_clr = 1'b1; b_clr = 1'b1; c_clr = 1'b1;
        end else if (xfer) begin
          cnt_inc = 1'b1;
          if (a_wrap) begin
            state_next = ST_PH_B;
            a_clr = 1'b1;
            b_one = 1'b1;
          end else begin
            a_inc = 1'b1;
          end
        end
      end

      ST_PH_B: begin
        if (abort) begin
          state_next = ST_IDLE;
          a_clr = 1'b1; b_clr = 1'b1; c_clr = 1'b1;
        end else if (xfer) begin
          cnt_inc = 1'b1;
          if (!a_wrap) begin
            a_inc = 1'b1;
          end else if (!b_wrap) begin
            a_clr = 1'b1;
            b_inc = 1'b1;
          end else begin
            state_next = ST_PH_C;
            a_clr = 1'b1;
            b_clr = 1'b1;
            c_one = 1'b1;
          end
        end
      end

      ST_PH_C: begin
        if (abort) begin
          state_next = ST_IDLE;
          a_clr = 1'b1; b_clr = 1'b1; c_clr = 1'b1;
        end else if (xfer) begin
          cnt_inc = 1'b1;
          if (!a_wrap) begin
            a_inc = 1'b1;
          end else if (!b_wrap) begin
            a_clr = 1'b1;
            b_inc = 1'b1;
          end else if (!c_wrap) begin
            a_clr = 1'b1;
            b_clr = 1'b1;
            c_inc = 1'b1;
          end else begin
            // final vector accepted: operands keep the last triple
            state_next = ST_DONE;
          end
        end
      end

      default: begin
        state_next = ST_IDLE;
        a_clr = 1'b1; b_clr = 1'b1; c_clr = 1'b1;
      end
    endcase
  end

  assign in_sweep_next = (state_next == ST_PH_A) || (state_next == ST_PH_B) ||
                         (state_next == ST_PH_C);

  // Look at the digits' next values so out_last is aligned with the vector.
  assign out_last_next = (state_next == ST_PH_C) &&
                         (a_nxt == MAX) && (b_nxt == MAX) && (c_nxt == MAX);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= ST_IDLE;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      phase     <= PH_CODE_REST;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state_reg <= state_next;
      out_valid <= in_sweep_next;
      out_last  <= out_last_next;
      phase     <= phase_of(state_next);
      busy      <= in_sweep_next;
      done      <= (state_next == ST_DONE);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      vec_cnt <= '0;
    else if (cnt_clr)
      vec_cnt <= '0;
    else if (cnt_inc && (vec_cnt != CNT_MAX))
      vec_cnt <= vec_cnt + CNT_W'(1);
  end

endmodule

// File: tb/tb_abc_sweep_gen.sv
// Testbench for abc_sweep_gen: table-driven control vectors, hand-written
// corner sequences and a randomized full sweep against a reference list.
module tb_abc_sweep_gen;
  import abc_sweep_gen_pkg::*;

  localparam int W     = 4;
  localparam int CNT_W = 3 * W + 1;
  localparam int NVEC  = 1 << (3 * W);

  logic             clk;
  logic             reset;
  logic             start;
  logic             abort;
  logic             out_ready;
  logic             out_valid;
  logic [W-1:0]     A_e, B_e, C_e;
  logic             out_last;
  logic [1:0]       phase;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] vec_cnt;

  int checks = 0;
  int errors = 0;

  abc_sweep_gen #(.W(W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .out_ready(out_ready), .out_valid(out_valid),
    .A_e(A_e), .B_e(B_e), .C_e(C_e), .out_last(out_last),
    .phase(phase), .busy(busy), .done(done), .vec_cnt(vec_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic start;
    logic abort;
    logic ready;
    int   valid;
    int   a;
    int   b;
    int   c;
    int   ph;
    int   cnt;
  } row_t;

  row_t tbl[9];

  // Reference sweep order built directly from the phase rules.
  int exp_a[NVEC];
  int exp_b[NVEC];
  int exp_c[NVEC];
  bit seen[NVEC];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_vec(input string name, input int a, input int b, input int c);
    check({name, ".A"}, int'(A_e), a);
    check({name, ".B"}, int'(B_e), b);
    check({name, ".C"}, int'(C_e), c);
  endtask

  // Run with out_ready=1 until the DUT presents (a,b,c); bounded.
  task automatic run_until(input int a, input int b, input int c, input int budget);
    int n;
    n = 0;
    out_ready = 1'b1;
    while (!(out_valid && int'(A_e) == a && int'(B_e) == b && int'(C_e) == c) && n < budget) begin
      step();
      n++;
    end
    if (n >= budget) check("run_until_timeout", 0, 1);
  endtask

  function automatic int exp_phase(input int idx);
    if (idx < 16) return 0;
    if (idx < 256) return 1;
    return 2;
  endfunction

  initial begin
    int k;
    int n;
    int uniq;
    bit xfer;
    int idx;

    k = 0;
    for (int a = 0; a <= MAX_DEF; a++) begin
      exp_a[k] = a; exp_b[k] = 0; exp_c[k] = 0; k++;
    end
    for (int b = 1; b <= MAX_DEF; b++)
      for (int a = 0; a <= MAX_DEF; a++) begin
        exp_a[k] = a; exp_b[k] = b; exp_c[k] = 0; k++;
      end
    for (int c = 1; c <= MAX_DEF; c++)
      for (int b = 0; b <= MAX_DEF; b++)
        for (int a = 0; a <= MAX_DEF; a++) begin
          exp_a[k] = a; exp_b[k] = b; exp_c[k] = c; k++;
        end

    //          start abort ready valid a  b  c  ph cnt
    tbl[0] = '{1'b0, 1'b0, 1'b0, 0, 0, 0, 0, 3, 0};
    tbl[1] = '{1'b1, 1'b0, 1'b0, 1, 0, 0, 0, 0, 0};
    tbl[2] = '{1'b0, 1'b0, 1'b1, 1, 1, 0, 0, 0, 1};
    tbl[3] = '{1'b1, 1'b0, 1'b0, 1, 1, 0, 0, 0, 1};
    tbl[4] = '{1'b0, 1'b0, 1'b1, 1, 2, 0, 0, 0, 2};
    tbl[5] = '{1'b0, 1'b1, 1'b1, 0, 0, 0, 0, 3, 2};
    tbl[6] = '{1'b0, 1'b1, 1'b0, 0, 0, 0, 0, 3, 2};
    tbl[7] = '{1'b1, 1'b1, 1'b0, 1, 0, 0, 0, 0, 0};
    tbl[8] = '{1'b0, 1'b1, 1'b1, 0, 0, 0, 0, 3, 0};

    reset = 1'b1; start = 1'b0; abort = 1'b0; out_ready = 1'b0;
    #1;
    check("rst.valid", int'(out_valid), 0);
    check("rst.phase", int'(phase), 3);
    check("rst.cnt", int'(vec_cnt), 0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    // Control vectors
    for (int i = 0; i < 9; i++) begin
      start = tbl[i].start; abort = tbl[i].abort; out_ready = tbl[i].ready;
      step();
      $display("row %0d: start=%0b abort=%0b ready=%0b -> valid=%0b (%0d,%0d,%0d) ph=%0d cnt=%0d",
               i, tbl[i].start, tbl[i].abort, tbl[i].ready, out_valid, A_e, B_e, C_e, phase, vec_cnt);
      check($sformatf("row%0d.valid", i), int'(out_valid), tbl[i].valid);
      check_vec($sformatf("row%0d", i), tbl[i].a, tbl[i].b, tbl[i].c);
      check($sformatf("row%0d.phase", i), int'(phase), tbl[i].ph);
      check($sformatf("row%0d.cnt", i), int'(vec_cnt), tbl[i].cnt);
    end
    start = 1'b0; abort = 1'b0; out_ready = 1'b0;

    // Start with ready held high: first vector one cycle after start
    start = 1'b1; out_ready = 1'b1;
    step();
    start = 1'b0;
    check("start.valid", int'(out_valid), 1);
    check("start.busy", int'(busy), 1);
    check_vec("start", 0, 0, 0);
    repeat (16) step();
    check_vec("phB_entry", 0, 1, 0);
    check("phB_entry.phase", int'(phase), 1);
    check("phB_entry.cnt", int'(vec_cnt), 16);
    $display("seq start: 16 transfers -> (%0d,%0d,%0d) ph=%0d", A_e, B_e, C_e, phase);

    // Phase boundaries B->C and inside C
    run_until(15, 15, 0, 400);
    step();
    check_vec("phC_entry", 0, 0, 1);
    check("phC_entry.phase", int'(phase), 2);
    check("phC_entry.cnt", int'(vec_cnt), 256);
    run_until(15, 15, 3, 1000);
    step();
    check_vec("c_carry", 0, 0, 4);
    check("c_carry.last", int'(out_last), 0);
    $display("seq boundary: now (%0d,%0d,%0d) cnt=%0d", A_e, B_e, C_e, vec_cnt);

    // Asynchronous reset mid-sweep, off the clock edge
    #2 reset = 1'b1;
    #1;
    check("arst.valid", int'(out_valid), 0);
    check_vec("arst", 0, 0, 0);
    check("arst.phase", int'(phase), 3);
    check("arst.busy", int'(busy), 0);
    check("arst.cnt", int'(vec_cnt), 0);
    step();
    reset = 1'b0;
    $display("seq async reset applied mid-cycle");

    // Backpressure at (5,0,0)
    start = 1'b1; out_ready = 1'b0;
    step();
    start = 1'b0;
    check_vec("restart", 0, 0, 0);
    run_until(5, 0, 0, 20);
    out_ready = 1'b0;
    for (int i = 0; i < 7; i++) begin
      step();
      check_vec("bp_hold", 5, 0, 0);
      check("bp_hold.valid", int'(out_valid), 1);
    end
    check("bp_hold.cnt", int'(vec_cnt), 5);
    out_ready = 1'b1;
    step();
    check_vec("bp_release", 6, 0, 0);
    check("bp_release.cnt", int'(vec_cnt), 6);
    $display("seq backpressure: released -> (%0d,%0d,%0d) cnt=%0d", A_e, B_e, C_e, vec_cnt);

    // Abort at vec_cnt=100, counter retained, then restart
    n = 0;
    while (int'(vec_cnt) != 100 && n < 200) begin
      step();
      n++;
    end
    check("abort_reach", int'(vec_cnt), 100);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("abort.valid", int'(out_valid), 0);
    check_vec("abort", 0, 0, 0);
    check("abort.phase", int'(phase), 3);
    check("abort.cnt", int'(vec_cnt), 100);
    $display("seq abort at cnt=100 -> ph=%0d cnt=%0d", phase, vec_cnt);

    // Full randomized-ready sweep against the reference order
    out_ready = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    check("sweep.cnt0", int'(vec_cnt), 0);
    for (int i = 0; i < NVEC; i++) seen[i] = 1'b0;
    idx = 0;
    n = 0;
    while (!done && n < 40000) begin
      if (out_valid) begin
        if (idx < NVEC) begin
          check_vec("sweep", exp_a[idx], exp_b[idx], exp_c[idx]);
          check("sweep.phase", int'(phase), exp_phase(idx));
          check("sweep.last", int'(out_last), (idx == NVEC - 1) ? 1 : 0);
        end else begin
          check("sweep.overrun", idx, NVEC - 1);
        end
        check("sweep.cnt", int'(vec_cnt), idx);
      end
      out_ready = 1'($urandom_range(0, 1));
      xfer = out_valid && out_ready;
      if (xfer) begin
        k = int'({C_e, B_e, A_e});
        if (seen[k]) check("sweep.duplicate", k, -1);
        seen[k] = 1'b1;
      end
      step();
      if (xfer) idx++;
      n++;
    end
    uniq = 0;
    for (int i = 0; i < NVEC; i++) if (seen[i]) uniq++;
    check("sweep.unique", uniq, NVEC);
    check("sweep.transfers", idx, NVEC);
    check("done.done", int'(done), 1);
    check("done.valid", int'(out_valid), 0);
    check("done.cnt", int'(vec_cnt), NVEC);
    check("done.phase", int'(phase), 3);
    check("done.busy", int'(busy), 0);
    check_vec("done.hold", 15, 15, 15);
    $display("seq full sweep: %0d transfers in %0d cycles, %0d unique", idx, n, uniq);

    // Restart from DONE; start beats a simultaneous abort
    start = 1'b1; abort = 1'b1; out_ready = 1'b0;
    step();
    start = 1'b0; abort = 1'b0;
    check("redo.valid", int'(out_valid), 1);
    check("redo.done", int'(done), 0);
    check_vec("redo", 0, 0, 0);
    check("redo.cnt", int'(vec_cnt), 0);
    $display("seq restart from done -> (%0d,%0d,%0d) ph=%0d", A_e, B_e, C_e, phase);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
